// File: rtl/link_ddr_rx_assembler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | link_ddr_rx_assembler                                                     |
// | DDR link receiver: beats -> CORE_W words -> FIFO -> core, credit tokens.  |
// | Optional: LINK_RX_PARITY_EN adds per-beat even-parity checking.           |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module link_ddr_rx_assembler #(
  parameter int PHY_W       = 8,
  parameter int CORE_W      = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int TOKEN_BATCH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          io_valid_i,
  input  logic [2*PHY_W-1:0]            io_data_i,
`ifdef LINK_RX_PARITY_EN
  input  logic                          io_parity_i,
`endif
  output logic                          core_valid_o,
  output logic [CORE_W-1:0]             core_data_o,
  input  logic                          core_ready_i,
  output logic                          token_o,
  output logic                          overflow_o,
  output logic                          parity_err_o,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy_o
);

  localparam int c_BW    = 2 * PHY_W;
  localparam int c_BEATS = CORE_W / c_BW;
  localparam int c_CW    = $clog2(c_BEATS);
  localparam int c_AW    = $clog2(FIFO_DEPTH);
  localparam int c_TW    = (TOKEN_BATCH > 1) ? $clog2(TOKEN_BATCH) : 1;
  localparam int c_PW    = CORE_W - c_BW;
  localparam logic [c_CW-1:0] c_LAST_BEAT = c_CW'(c_BEATS - 1);
  localparam logic [c_TW-1:0] c_LAST_DEQ  = c_TW'(TOKEN_BATCH - 1);

  logic [c_CW-1:0]   r_beat_cnt;
  logic [c_PW-1:0]   r_partial;
  logic [CORE_W-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW:0]     r_wptr;
  logic [c_AW:0]     r_rptr;
  logic [c_TW-1:0]   r_deq_cnt;
  logic              r_token;
  logic              r_overflow;

  logic              w_last;
  logic              w_word_bad;
  logic              w_empty;
  logic              w_full;
  logic              w_deq;
  logic              w_enq;
  logic              w_drop;
  logic [CORE_W-1:0] w_word;

  assign w_last  = io_valid_i && (r_beat_cnt == c_LAST_BEAT);
  assign w_word  = {io_data_i, r_partial};
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                   (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
  assign w_deq   = !w_empty && core_ready_i;
  // Full is judged before this cycle's dequeue, so a same-cycle dequeue frees the slot.
  assign w_enq   = w_last && !w_word_bad && (!w_full || w_deq);
  assign w_drop  = w_last && !w_word_bad && w_full && !w_deq;

`ifdef LINK_RX_PARITY_EN
  logic r_word_bad;
  logic r_parity_err;
  logic w_beat_bad;

  assign w_beat_bad   = io_valid_i && (^{io_data_i, io_parity_i});
  assign w_word_bad   = r_word_bad || w_beat_bad;
  assign parity_err_o = r_parity_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_bad   <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_beat_bad) r_parity_err <= 1'b1;
      if (w_last)          r_word_bad <= 1'b0;
      else if (w_beat_bad) r_word_bad <= 1'b1;
    end
  end
`else
  assign w_word_bad   = 1'b0;
  assign parity_err_o = 1'b0;
`endif

  // The final beat is never stored; it is merged straight into the enqueued word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt <= '0;
      r_partial  <= '0;
    end else if (io_valid_i) begin
      if (w_last) begin
        r_beat_cnt <= '0;
        r_partial  <= '0;
      end else begin
        r_beat_cnt <= r_beat_cnt + c_CW'(1);
        for (int k = 0; k < c_BEATS - 1; k++) begin
          if (r_beat_cnt == c_CW'(k)) r_partial[k*c_BW +: c_BW] <= io_data_i;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_wptr[c_AW-1:0]] <= w_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_enq)  r_wptr     <= r_wptr + (c_AW+1)'(1);
      if (w_deq)  r_rptr     <= r_rptr + (c_AW+1)'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_deq_cnt <= '0;
      r_token   <= 1'b0;
    end else if (w_deq) begin
      if (r_deq_cnt == c_LAST_DEQ) begin
        r_deq_cnt <= '0;
        r_token   <= ~r_token;
      end else begin
        r_deq_cnt <= r_deq_cnt + c_TW'(1);
      end
    end
  end

  assign core_valid_o = !w_empty;
  assign core_data_o  = r_mem[r_rptr[c_AW-1:0]];
  assign token_o      = r_token;
  assign overflow_o   = r_overflow;
  assign occupancy_o  = r_wptr - r_rptr;

endmodule
`default_nettype wire

// File: tb/tb_link_ddr_rx_assembler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_link_ddr_rx_assembler                                                  |
// | Directed plus random stimulus against a queue-based reference model.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_link_ddr_rx_assembler;

  localparam int PHY_W  = 8;
  localparam int CORE_W = 32;
  localparam int DEPTH  = 8;
  localparam int TBATCH = 4;
  localparam int BEATS  = CORE_W / (2 * PHY_W);
`ifdef LINK_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              io_valid_i;
  logic [15:0]       io_data_i;
  logic              io_parity_i;
  logic              core_valid_o;
  logic [31:0]       core_data_o;
  logic              core_ready_i;
  logic              token_o;
  logic              overflow_o;
  logic              parity_err_o;
  logic [3:0]        occupancy_o;

  link_ddr_rx_assembler #(
    .PHY_W(PHY_W), .CORE_W(CORE_W), .FIFO_DEPTH(DEPTH), .TOKEN_BATCH(TBATCH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .io_valid_i   (io_valid_i),
    .io_data_i    (io_data_i),
`ifdef LINK_RX_PARITY_EN
    .io_parity_i  (io_parity_i),
`endif
    .core_valid_o (core_valid_o),
    .core_data_o  (core_data_o),
    .core_ready_i (core_ready_i),
    .token_o      (token_o),
    .overflow_o   (overflow_o),
    .parity_err_o (parity_err_o),
    .occupancy_o  (occupancy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: words awaiting the core, beats of the word in flight.
  logic [31:0] m_q[$];
  logic [15:0] m_beats[$];
  bit          m_tok, m_ovf, m_perr, m_bad;
  int          m_deqs;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_beats.delete();
    m_tok = 0; m_ovf = 0; m_perr = 0; m_bad = 0; m_deqs = 0;
  endtask

  task automatic model_step(input bit v, input logic [15:0] d, input bit rdy, input bit inj);
    bit deq;
    bit full;
    logic [31:0] word;
    deq  = (m_q.size() != 0) && rdy;
    full = (m_q.size() == DEPTH);
    if (deq) begin
      void'(m_q.pop_front());
      m_deqs++;
      if (m_deqs % TBATCH == 0) m_tok = !m_tok;
    end
    if (v) begin
      if (inj && PAR_ON) begin m_bad = 1; m_perr = 1; end
      m_beats.push_back(d);
      if (m_beats.size() == BEATS) begin
        word = 0;
        for (int k = 0; k < BEATS; k++) word = word | (32'(m_beats[k]) << (16 * k));
        if (!m_bad) begin
          if (!full || deq) m_q.push_back(word);
          else              m_ovf = 1;
        end
        m_beats.delete();
        m_bad = 0;
      end
    end
  endtask

  // One clock: drive, compare at negedge, advance the model, cross posedge.
  task automatic tick(input bit v, input logic [15:0] d, input bit rdy,
                      input bit rs = 0, input bit inj = 0);
    io_valid_i   = v;
    io_data_i    = d;
    core_ready_i = rdy;
    rst          = rs;
    io_parity_i  = (^d) ^ inj;
    @(negedge clk);
    check("valid", core_valid_o, m_q.size() != 0);
    if (m_q.size() != 0) check("data", core_data_o, m_q[0]);
    check("occupancy", occupancy_o, m_q.size());
    check("token", token_o, m_tok);
    check("overflow", overflow_o, m_ovf);
    check("parity_err", parity_err_o, m_perr);
    if (rs) model_reset();
    else    model_step(v, d, rdy, inj);
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit rdy);
    tick(1, w[15:0], rdy);
    tick(1, w[31:16], rdy);
  endtask

  initial begin
    logic [31:0] w;
    rst = 1; io_valid_i = 0; io_data_i = 0; io_parity_i = 0; core_ready_i = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state, then a basic word with ready high.
    tick(0, 0, 1);
    tick(1, 16'h2211, 1);
    tick(1, 16'h4433, 1);
    check("basic_valid", core_valid_o, 1);
    check("basic_data", core_data_o, 32'h4433_2211);
    tick(0, 0, 1);
    check("basic_drain", occupancy_o, 0);

    // Idle gap inside a word.
    tick(1, 16'hBBAA, 1);
    repeat (5) tick(0, 16'hFFFF, 1);
    tick(1, 16'hDDCC, 1);
    check("gap_data", core_data_o, 32'hDDCC_BBAA);
    tick(0, 0, 1);

    // Nine words with the core stalled: the ninth is dropped.
    for (int i = 1; i <= 9; i++) send_word({16'(i * 2 + 1), 16'(i * 2)}, 0);
    check("fill_occ", occupancy_o, DEPTH);
    check("fill_ovf", overflow_o, 1);
    repeat (10) tick(0, 0, 1);

    // Full FIFO with the last beat coinciding with a dequeue.
    tick(0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) send_word($urandom, 0);
    w = $urandom;
    tick(1, w[15:0], 0);
    tick(1, w[31:16], 1);
    check("full_deq_occ", occupancy_o, DEPTH);
    check("full_deq_ovf", overflow_o, 0);
    repeat (DEPTH + 2) tick(0, 0, 1);

    // Reset after beat 0 discards the stale half.
    tick(1, 16'hDEAD, 0);
    tick(1, 16'hBEEF, 0, 1);
    tick(1, 16'h5678, 1);
    tick(1, 16'h1234, 1);
    check("rst_mid_data", core_data_o, 32'h1234_5678);
    tick(0, 0, 1);

`ifdef LINK_RX_PARITY_EN
    send_word(32'h1111_0001, 0);
    tick(1, 16'h0002, 0);
    tick(1, 16'h2222, 0, 0, 1);
    send_word(32'h3333_0003, 0);
    check("par_err", parity_err_o, 1);
    check("par_occ", occupancy_o, 2);
    repeat (3) tick(0, 0, 1);
`endif

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      bit rdy;
      rdy = (c % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      tick($urandom_range(0, 3) != 0, 16'($urandom), rdy,
           $urandom_range(0, 299) == 0, PAR_ON && ($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
